// File: rtl/remap_sched.sv
// remap_sched: four-requester round-robin scheduler feeding one shared remap
// datapath through a two-stage pipeline (operand stage, response stage).
//
// Ports:
//   clk_i        - sole clock, all state on the rising edge
//   rst_i        - asynchronous active-high reset
//   req_valid_i  - per-requester operand valid
//   req_num_i    - packed operands, requester i at [i*NUM_W +: NUM_W]
//   req_ready_o  - per-requester accept (one-hot or zero)
//   dp_num_o     - registered operand driven into the remap datapath
//   dp_rslt_i    - combinational datapath result for dp_num_o
//   rsp_valid_o  - response valid
//   rsp_id_o     - requester owning the response
//   rsp_rslt_o   - registered datapath result
//   rsp_ready_i  - response consumer accept
//   stat_sel_i   - grant counter select   (REMAP_SCHED_STATS_EN only)
//   stat_cnt_o   - selected grant count   (REMAP_SCHED_STATS_EN only)
//
// Optional feature macro: REMAP_SCHED_STATS_EN adds four saturating 16-bit
// per-requester handshake counters.
module remap_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*NUM_W-1:0] req_num_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_W-1:0]         dp_num_o,
    input  logic [NUM_W-1:0]         dp_rslt_i,
    output logic                     rsp_valid_o,
    output logic [1:0]               rsp_id_o,
    output logic [NUM_W-1:0]         rsp_rslt_o,
    input  logic                     rsp_ready_i
`ifdef REMAP_SCHED_STATS_EN
    ,
    input  logic [1:0]               stat_sel_i,
    output logic [15:0]              stat_cnt_o
`endif
);

    logic             op_valid_q, op_valid_d;
    logic [1:0]       op_id_q, op_id_d;
    logic [NUM_W-1:0] dp_num_q, dp_num_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic [NUM_W-1:0] rsp_rslt_q, rsp_rslt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_id;
    logic               grant_any;
    logic               stage0_accept;
    logic               stage1_accept;
    logic               req_hs;

    // Round-robin scan starting at rr_ptr_q; first valid requester wins.
    always_comb begin
        logic [1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr_q + k[1:0];
            if (!grant_any && req_valid_i[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        grant[grant_id] = grant_any;
    end

    assign stage1_accept = !rsp_valid_q || rsp_ready_i;
    assign stage0_accept = !op_valid_q || stage1_accept;

    // Ready is gated by reset so nothing is accepted while rst_i is high.
    assign req_ready_o = grant & {NUM_REQ{stage0_accept && !rst_i}};
    assign req_hs      = grant_any && stage0_accept && !rst_i;

    always_comb begin
        op_valid_d  = op_valid_q;
        op_id_d     = op_id_q;
        dp_num_d    = dp_num_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rslt_d  = rsp_rslt_q;

        if (stage0_accept) begin
            op_valid_d = req_hs;
            if (req_hs) begin
                op_id_d  = grant_id;
                dp_num_d = req_num_i[int'(grant_id)*NUM_W +: NUM_W];
                rr_ptr_d = grant_id + 2'd1;
            end
        end

        // When the response stage drains with no operand behind it only the
        // valid drops; id/result hold their last values.
        if (stage1_accept) begin
            rsp_valid_d = op_valid_q;
            if (op_valid_q) begin
                rsp_id_d   = op_id_q;
                rsp_rslt_d = dp_rslt_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_valid_q  <= 1'b0;
            op_id_q     <= '0;
            dp_num_q    <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rslt_q  <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_id_q     <= op_id_d;
            dp_num_q    <= dp_num_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rslt_q  <= rsp_rslt_d;
        end
    end

    assign dp_num_o    = dp_num_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_rslt_o  = rsp_rslt_q;

`ifdef REMAP_SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (req_hs && (cnt_q[grant_id] != '1)) begin
            cnt_q[grant_id] <= cnt_q[grant_id] + 16'd1;
        end
    end

    assign stat_cnt_o = cnt_q[stat_sel_i];
`endif

endmodule

// File: tb/tb_remap_sched.sv
module tb_remap_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_num;
    logic [3:0]   req_ready;
    logic [31:0]  dp_num;
    logic [31:0]  dp_rslt;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_rslt;
    logic         rsp_ready;
`ifdef REMAP_SCHED_STATS_EN
    logic [1:0]   stat_sel;
    logic [15:0]  stat_cnt;
`endif

    logic [31:0] num [4];

    always #5 clk = ~clk;

    assign req_num = {num[3], num[2], num[1], num[0]};
    assign dp_rslt = dp_num ^ 32'hFFFF_FFFF;

    remap_sched #(.NUM_REQ(4), .NUM_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_num_i   (req_num),
        .req_ready_o (req_ready),
        .dp_num_o    (dp_num),
        .dp_rslt_i   (dp_rslt),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_rslt_o  (rsp_rslt),
        .rsp_ready_i (rsp_ready)
`ifdef REMAP_SCHED_STATS_EN
        ,
        .stat_sel_i  (stat_sel),
        .stat_cnt_o  (stat_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rslt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted response is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id %0d rslt %h expected none", rsp_id, rsp_rslt);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_rslt", rsp_rslt, e.rslt);
            end
        end
    end

    // Present mask, wait for a grant, check it is exp_id, push the expected
    // response, then step past the handshake edge and load a fresh operand.
    task automatic issue(input logic [3:0] mask, input int exp_id);
        int n;
        exp_t e;
        logic [3:0] oh;
        n = 0;
        req_valid = mask;
        @(negedge clk);
        while (req_ready == 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        oh = 4'b0001 << exp_id;
        check("grant", 32'(req_ready), 32'(oh));
        e.id   = 2'(exp_id);
        e.rslt = num[exp_id] ^ 32'hFFFF_FFFF;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        num[exp_id] = num[exp_id] + 32'h0000_0100;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int start;
    logic [31:0] e0;
    logic [31:0] d1;

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        num[0] = 32'hA000_0000;
        num[1] = 32'hA100_0000;
        num[2] = 32'hA200_0000;
        num[3] = 32'hA300_0000;
`ifdef REMAP_SCHED_STATS_EN
        stat_sel = 2'd0;
`endif

        // Reset state, ready gated while reset is high.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_rslt", rsp_rslt, 32'd0);
        check("rst_dp_num", dp_num, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b0000;
        num[0] = 32'h0000_0001;

        // Single request, latency through both stages.
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_grant", 32'(req_ready), 32'h1);
        exp_q.push_back('{id: 2'd0, rslt: 32'hFFFF_FFFE});
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("t1_lat_early", 32'(rsp_valid), 32'd0);
        check("t1_dp_num", dp_num, 32'h0000_0001);
        @(negedge clk);
        check("t1_lat_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // All four valid: grants 0,1,2,3,0,1,2,3 with one response per cycle.
        do_reset();
        start = rsp_cnt;
        for (int i = 0; i < 8; i++) begin
            issue(4'hF, i % 4);
        end
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        check("t2_throughput", 32'(rsp_cnt - start), 32'd8);
        @(posedge clk);
        #1;
        drain();

        // Pointer at 2 with only 0 and 3 valid: 3 then 0, pointer ends at 1.
        issue(4'b0010, 1);
        issue(4'b1001, 3);
        issue(4'b0001, 0);
        issue(4'b1111, 1);
        req_valid = 4'b0000;
        drain();

        // Stall with two operations in flight.
        start = rsp_cnt;
        rsp_ready = 1'b0;
        e0 = num[0] ^ 32'hFFFF_FFFF;
        d1 = num[1];
        issue(4'b0001, 0);
        issue(4'b0010, 1);
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ready", 32'(req_ready), 32'd0);
            check("t4_valid", 32'(rsp_valid), 32'd1);
            check("t4_id", 32'(rsp_id), 32'd0);
            check("t4_rslt", rsp_rslt, e0);
            check("t4_dp_num", dp_num, d1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(4'b0100, 2);
        req_valid = 4'b0000;
        drain();
        check("t4_count", 32'(rsp_cnt - start), 32'd3);

        // Reset pulsed with both stages occupied.
        rsp_ready = 1'b0;
        issue(4'b0001, 0);
        issue(4'b0010, 1);
        req_valid = 4'b1111;
        @(negedge clk);
        check("t5_pre_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        start = rsp_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        #1;
        check("t5_no_rsp", 32'(rsp_cnt - start), 32'd0);
        check("t5_dp_num", dp_num, 32'd0);
        @(posedge clk);
        #1;
        issue(4'hF, 0);
        req_valid = 4'b0000;
        drain();

`ifdef REMAP_SCHED_STATS_EN
        do_reset();
        stat_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            issue(4'b0010, 1);
        end
        req_valid = 4'b0000;
        check("stat_req1", 32'(stat_cnt), 32'd3);
        drain();
        stat_sel = 2'd2;
        for (int i = 0; i < 65540; i++) begin
            issue(4'b0100, 2);
        end
        req_valid = 4'b0000;
        check("stat_req2_sat", 32'(stat_cnt), 32'h0000_FFFF);
        drain();
        stat_sel = 2'd1;
        #1;
        check("stat_req1_hold", 32'(stat_cnt), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
